forward_scoreboard: RTL and testbench
=====================================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter NUM_RD, default 2, meaning read ports per instruction (1..4).
REQ-002 SHALL have parameter LAT_W, default 4, meaning width of multi-cycle latency field (max latency 2^LAT_W-1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports id_valid  input  1, id_rs  input  NUM_RD*5, id_rs_used  input  NUM_RD, id_branch  input  1 (operands compared in ID).
REQ-006 SHALL have ports id_we  input  1, id_rd  input  5, id_lat  input  LAT_W (0 = single-cycle pipeline op; >0 = multi-cycle unit op).
REQ-007 SHALL have ports ex_rs  input  NUM_RD*5, ex_we  input  1, ex_rd  input  5, ex_is_load  input  1.
REQ-008 SHALL have ports mem_we  input  1, mem_rd  input  5, mem_is_load  input  1, wb_we  input  1, wb_rd  input  5, flush  input  1.
REQ-009 SHALL have ports id_fwd  output  NUM_RD (1 = take MEM result), ex_fwd  output  NUM_RD*2 (10 MEM, 01 WB, 00 regfile), stall  output  1.

Function
REQ-010 SHALL hold per register 1..31 a pending bit and LAT_W-bit countdown; register 0 never pending.
REQ-011 SHALL, on id_valid && !stall && !flush && id_we && id_rd!=0 && id_lat>0, set pending[id_rd] and load count=id_lat at next edge.
REQ-012 SHALL decrement every nonzero count each cycle; pending clears on the edge where count goes 1->0.
REQ-013 SHALL, when a register both finishes (1->0) and is reissued in the same cycle, give the reissue priority (pending stays 1, count=id_lat).
REQ-014 SHALL drive ex_fwd[i]=10 when mem_we && mem_rd!=0 && mem_rd==ex_rs[i]; else 01 when wb_we && wb_rd!=0 && wb_rd==ex_rs[i]; else 00.
REQ-015 SHALL drive id_fwd[i]=1 when id_branch && id_rs_used[i] && mem_we && !mem_is_load && mem_rd!=0 && mem_rd==id_rs[i].
REQ-016 SHALL assert stall (combinational, same cycle) when id_valid and any used id_rs[i]!=0 meets: pending[id_rs[i]] (RAW on multi-cycle), OR ex_is_load && ex_we && ex_rd==id_rs[i] (load-use), OR id_branch && ex_we && ex_rd==id_rs[i] (branch on EX result), OR id_branch && mem_is_load && mem_rd==id_rs[i].
REQ-017 SHALL assert stall on WAW: id_valid && id_we && id_rd!=0 && pending[id_rd] && count[id_rd] > id_lat.
REQ-018 SHALL keep stall deasserted when id_valid=0; flush SHALL suppress scoreboard set but not clear existing pending entries.
REQ-019 SHALL give no-ID-source-used (id_rs_used=0) zero stall regardless of register match.

Reset
REQ-020 SHALL, on rst_n low, clear all pending bits and counts asynchronously; outputs then depend only on inputs (stall=0 if no ex/mem load match).
REQ-021 SHALL, on reset mid-operation, abandon all in-flight counts; first post-reset edge behaves as fresh.

Configuration
REQ-022 SHALL, with FWD_STALL_CNT_EN defined, add output stall_cnt  output  32, incrementing each cycle stall=1, wrapping at 2^32-1 -> 0, reset to 0.
REQ-023 SHALL, without FWD_STALL_CNT_EN, omit stall_cnt port and its logic entirely.

Structure
REQ-024 SHALL place fwd_sel_t encoding (NONE=00, WB=01, MEM=10) and REG_AW=5 in shared package fwd_pkg.
REQ-025 SHALL implement per-register pending/count as sub-module sb_entry, instantiated 31 times.

Verification
REQ-026 Load to r8 in EX, ID uses r8 -> stall=1 one cycle; next cycle ex_fwd=10 for that port.
REQ-027 MEM writes r3, WB writes r3, EX reads r3 -> ex_fwd=10; MEM r0 write to r0 reader -> 00.
REQ-028 Issue mul r5 id_lat=3 -> ID reading r5 stalls exactly 3 cycles, released on 4th.
REQ-029 r9 pending count=4, issue r9 id_lat=2 -> WAW stall until count<=2; id_lat=6 -> no stall, count reloads 6.
REQ-030 Branch reading r4, MEM ALU writes r4 -> id_fwd=1, stall=0; MEM load writes r4 -> stall=1.
REQ-031 rst_n low with 3 pending entries -> all clear immediately; with FWD_STALL_CNT_EN, stall_cnt=0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/scoreboard block: forwarding-select encoding,
// register address width and the EX-stage forwarding priority function.
package fwd_pkg;

    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        WB   = 2'b01,
        MEM  = 2'b10
    } fwd_sel_t;

    // The younger producer (MEM) wins over WB; writes to r0 never forward.
    function automatic fwd_sel_t pick_fwd(
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [REG_AW-1:0] rs
    );
        if (mem_we && mem_rd != '0 && mem_rd == rs) begin
            return MEM;
        end
        if (wb_we && wb_rd != '0 && wb_rd == rs) begin
            return WB;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: pending flag plus countdown of remaining multi-cycle latency.
// A new issue takes priority over the slot finishing in the same cycle.
module sb_entry #(
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [LAT_W-1:0] set_lat,
    output logic             pending,
    output logic [LAT_W-1:0] count
);

    logic             pending_q, pending_d;
    logic [LAT_W-1:0] count_q,   count_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        if (set_en) begin
            pending_d = 1'b1;
            count_d   = set_lat;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
            if (count_q == LAT_W'(1)) begin
                pending_d = 1'b0;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all slots update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending = pending_q;
    assign count   = count_q;

endmodule

// File: rtl/forward_scoreboard.sv
// Operand forwarding selects, multi-cycle RAW/WAW scoreboard and pipeline stall.
// Optional build macro FWD_STALL_CNT_EN adds a 32-bit free-running stall-cycle counter.
module forward_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int LAT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NUM_RD*REG_AW-1:0] id_rs,
    input  logic [NUM_RD-1:0]        id_rs_used,
    input  logic                     id_branch,
    input  logic                     id_we,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic [LAT_W-1:0]         id_lat,
    input  logic [NUM_RD*REG_AW-1:0] ex_rs,
    input  logic                     ex_we,
    input  logic [REG_AW-1:0]        ex_rd,
    input  logic                     ex_is_load,
    input  logic                     mem_we,
    input  logic [REG_AW-1:0]        mem_rd,
    input  logic                     mem_is_load,
    input  logic                     wb_we,
    input  logic [REG_AW-1:0]        wb_rd,
    input  logic                     flush,
    output logic [NUM_RD-1:0]        id_fwd,
    output logic [NUM_RD*2-1:0]      ex_fwd,
    output logic                     stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    logic [NUM_REGS-1:0] pending;
    logic [LAT_W-1:0]    count [NUM_REGS];
    logic [REG_AW-1:0]   id_src [NUM_RD];
    logic [REG_AW-1:0]   ex_src [NUM_RD];
    logic                raw_hit;
    logic                waw_hit;
    logic                issue;

    assign pending[0] = 1'b0;
    assign count[0]   = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(
            .LAT_W  (LAT_W)
        ) u_entry (
            .clk    (clk),
            .rst_n  (rst_n),
            .set_en (issue && (id_rd == REG_AW'(r))),
            .set_lat(id_lat),
            .pending(pending[r]),
            .count  (count[r])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            id_src[i] = id_rs[i*REG_AW +: REG_AW];
            ex_src[i] = ex_rs[i*REG_AW +: REG_AW];
        end
    end

    always_comb begin
        id_fwd = '0;
        ex_fwd = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ex_fwd[2*i +: 2] = pick_fwd(mem_we, mem_rd, wb_we, wb_rd, ex_src[i]);
            id_fwd[i] = id_branch && id_rs_used[i] && mem_we && !mem_is_load &&
                        (mem_rd != '0) && (mem_rd == id_src[i]);
        end
    end

    // Branches resolve in ID, so any EX producer or a MEM load cannot reach them in time.
    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (id_rs_used[i] && id_src[i] != '0) begin
                if (pending[id_src[i]]) begin
                    raw_hit = 1'b1;
                end
                if (ex_we && (ex_rd == id_src[i]) && (ex_is_load || id_branch)) begin
                    raw_hit = 1'b1;
                end
                if (id_branch && mem_is_load && (mem_rd == id_src[i])) begin
                    raw_hit = 1'b1;
                end
            end
        end
        waw_hit = id_we && (id_rd != '0) && pending[id_rd] && (count[id_rd] > id_lat);
        stall   = id_valid && (raw_hit || waw_hit);
    end

    assign issue = id_valid && !stall && !flush && id_we && (id_rd != '0) && (id_lat != '0);

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scenario-driven bench for forward_scoreboard: each cycle pushes the expected
// {stall, id_fwd, ex_fwd} to a queue and pops it when the outputs are sampled.
module tb_forward_scoreboard;

    localparam int NUM_RD = 2;
    localparam int LAT_W  = 4;
    localparam int OW     = 1 + 3*NUM_RD;

    typedef struct {
        string         name;
        logic [OW-1:0] val;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  id_valid;
    logic [NUM_RD*5-1:0]   id_rs;
    logic [NUM_RD-1:0]     id_rs_used;
    logic                  id_branch;
    logic                  id_we;
    logic [4:0]            id_rd;
    logic [LAT_W-1:0]      id_lat;
    logic [NUM_RD*5-1:0]   ex_rs;
    logic                  ex_we;
    logic [4:0]            ex_rd;
    logic                  ex_is_load;
    logic                  mem_we;
    logic [4:0]            mem_rd;
    logic                  mem_is_load;
    logic                  wb_we;
    logic [4:0]            wb_rd;
    logic                  flush;
    logic [NUM_RD-1:0]     id_fwd;
    logic [NUM_RD*2-1:0]   ex_fwd;
    logic                  stall;
`ifdef FWD_STALL_CNT_EN
    logic [31:0]           stall_cnt;
`endif

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    forward_scoreboard #(
        .NUM_RD     (NUM_RD),
        .LAT_W      (LAT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_branch  (id_branch),
        .id_we      (id_we),
        .id_rd      (id_rd),
        .id_lat     (id_lat),
        .ex_rs      (ex_rs),
        .ex_we      (ex_we),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_is_load(mem_is_load),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .id_fwd     (id_fwd),
        .ex_fwd     (ex_fwd),
        .stall      (stall)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic clear_inputs();
        id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_branch = 1'b0;
        id_we = 1'b0; id_rd = '0; id_lat = '0;
        ex_rs = '0; ex_we = 1'b0; ex_rd = '0; ex_is_load = 1'b0;
        mem_we = 1'b0; mem_rd = '0; mem_is_load = 1'b0;
        wb_we = 1'b0; wb_rd = '0; flush = 1'b0;
    endtask

    task automatic drive_issue(input logic [4:0] rd, input logic [LAT_W-1:0] lat);
        clear_inputs();
        id_valid = 1'b1; id_we = 1'b1; id_rd = rd; id_lat = lat;
    endtask

    task automatic drive_reader(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
        clear_inputs();
        id_valid = 1'b1; id_rs = {rs1, rs0}; id_rs_used = used;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) next_cycle();
    endtask

    // Reset held: outputs still follow the combinational inputs.
    task automatic test_reset();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            clear_inputs();
            case (k)
                0: exp_q.push_back('{"reset_idle", 7'b0_00_0000});
                1: begin
                    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd8;
                    id_valid = 1'b1; id_rs = {5'd0, 5'd8}; id_rs_used = 2'b01;
                    exp_q.push_back('{"reset_load_use", 7'b1_00_0000});
                end
                default: begin
                    mem_we = 1'b1; mem_rd = 5'd3; ex_rs = {5'd3, 5'd3};
                    exp_q.push_back('{"reset_ex_fwd", 7'b0_00_1010});
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, id_fwd, ex_fwd} !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, {stall, id_fwd, ex_fwd}, e.val);
            end
        end
        next_cycle();
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            int p;
            p = k / 2;
            next_cycle();
            clear_inputs();
            if (k % 2 == 0) begin
                ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd8;
                id_valid = 1'b1; id_rs_used = 2'b11;
                id_rs = (p == 0) ? {5'd1, 5'd8} : {5'd8, 5'd1};
                exp_q.push_back('{$sformatf("load_use_stall[p%0d]", p), 7'b1_00_0000});
            end else begin
                mem_we = 1'b1; mem_rd = 5'd8; mem_is_load = 1'b1;
                ex_rs = (p == 0) ? {5'd1, 5'd8} : {5'd8, 5'd1};
                exp_q.push_back('{$sformatf("load_use_fwd[p%0d]", p),
                                  (p == 0) ? 7'b0_00_0010 : 7'b0_00_1000});
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, id_fwd, ex_fwd} !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, {stall, id_fwd, ex_fwd}, e.val);
            end
        end
    endtask

    task automatic test_ex_fwd();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            clear_inputs();
            case (k)
                0: begin
                    mem_we = 1'b1; mem_rd = 5'd3; wb_we = 1'b1; wb_rd = 5'd3; ex_rs = {5'd7, 5'd3};
                    exp_q.push_back('{"ex_fwd_mem_over_wb", 7'b0_00_0010});
                end
                1: begin
                    mem_we = 1'b1; mem_rd = 5'd3; wb_we = 1'b1; wb_rd = 5'd7; ex_rs = {5'd7, 5'd3};
                    exp_q.push_back('{"ex_fwd_mem_and_wb", 7'b0_00_0110});
                end
                2: begin
                    mem_we = 1'b0; mem_rd = 5'd3; wb_we = 1'b1; wb_rd = 5'd3; ex_rs = {5'd3, 5'd3};
                    exp_q.push_back('{"ex_fwd_wb_only", 7'b0_00_0101});
                end
                3: begin
                    mem_we = 1'b1; mem_rd = 5'd0; wb_we = 1'b1; wb_rd = 5'd0; ex_rs = {5'd0, 5'd0};
                    exp_q.push_back('{"ex_fwd_r0", 7'b0_00_0000});
                end
                default: begin
                    mem_we = 1'b1; mem_rd = 5'd0; wb_we = 1'b1; wb_rd = 5'd5; ex_rs = {5'd5, 5'd0};
                    exp_q.push_back('{"ex_fwd_r0_mixed", 7'b0_00_0100});
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, id_fwd, ex_fwd} !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, {stall, id_fwd, ex_fwd}, e.val);
            end
        end
    endtask

    // mul r5 latency 3: a reader of r5 stalls three cycles and is released on the fourth.
    task automatic test_multicycle();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            if (k == 0) begin
                drive_issue(5'd5, 4'd3);
                exp_q.push_back('{"mc_issue", 7'b0_00_0000});
            end else begin
                drive_reader(5'd0, 5'd5, 2'b10);
                exp_q.push_back('{$sformatf("mc_read[%0d]", k), (k < 4) ? 7'b1_00_0000 : 7'b0_00_0000});
            end
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, id_fwd, ex_fwd} !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, {stall, id_fwd, ex_fwd}, e.val);
            end
        end
    endtask

    task automatic test_waw();
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            logic exp_stall;
            next_cycle();
            if (k == 0) begin
                drive_issue(5'd9, 4'd4);
                exp_stall = 1'b0;
            end else if (k <= 3) begin
                drive_issue(5'd9, 4'd2);
                exp_stall = (k < 3);
            end else if (k == 4) begin
                drive_issue(5'd9, 4'd6);
                exp_stall = 1'b0;
            end else begin
                drive_reader(5'd9, 5'd0, 2'b01);
                exp_stall = (k <= 10);
            end
            exp_q.push_back('{$sformatf("waw[%0d]", k), {exp_stall, 6'b00_0000}});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, id_fwd, ex_fwd} !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, {stall, id_fwd, ex_fwd}, e.val);
            end
        end
    endtask

    // Reissue on the cycle the entry finishes must win over the clear.
    task automatic test_reissue();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            case (k)
                0: drive_issue(5'd10, 4'd1);
                1: drive_issue(5'd10, 4'd2);
                default: drive_reader(5'd10, 5'd0, 2'b01);
            endcase
            exp_q.push_back('{$sformatf("reissue[%0d]", k),
                              (k == 2 || k == 3) ? 7'b1_00_0000 : 7'b0_00_0000});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, id_fwd, ex_fwd} !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, {stall, id_fwd, ex_fwd}, e.val);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            drive_reader(5'd4, 5'd0, 2'b01);
            id_branch = 1'b1;
            case (k)
                0: begin
                    mem_we = 1'b1; mem_rd = 5'd4;
                    exp_q.push_back('{"br_mem_alu_fwd", 7'b0_01_0000});
                end
                1: begin
                    mem_we = 1'b1; mem_rd = 5'd4; mem_is_load = 1'b1;
                    exp_q.push_back('{"br_mem_load", 7'b1_00_0000});
                end
                2: begin
                    ex_we = 1'b1; ex_rd = 5'd4;
                    exp_q.push_back('{"br_ex_alu", 7'b1_00_0000});
                end
                3: begin
                    id_branch = 1'b0; ex_we = 1'b1; ex_rd = 5'd4; mem_we = 1'b1; mem_rd = 5'd4;
                    exp_q.push_back('{"nonbr_alu", 7'b0_00_0000});
                end
                4: begin
                    id_rs_used = 2'b00; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4;
                    mem_is_load = 1'b1; mem_rd = 5'd4;
                    exp_q.push_back('{"br_no_src_used", 7'b0_00_0000});
                end
                5: begin
                    id_valid = 1'b0; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4;
                    exp_q.push_back('{"br_not_valid", 7'b0_00_0000});
                end
                6: begin
                    id_rs = {5'd4, 5'd2}; id_rs_used = 2'b10; mem_we = 1'b1; mem_rd = 5'd4;
                    exp_q.push_back('{"br_port1_fwd", 7'b0_10_0000});
                end
                default: begin
                    id_rs = {5'd0, 5'd0}; ex_we = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0;
                    mem_we = 1'b1; mem_rd = 5'd0;
                    exp_q.push_back('{"br_r0", 7'b0_00_0000});
                end
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, id_fwd, ex_fwd} !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, {stall, id_fwd, ex_fwd}, e.val);
            end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            case (k)
                0: begin drive_issue(5'd12, 4'd3); flush = 1'b1; end
                1: drive_reader(5'd12, 5'd0, 2'b01);
                2: drive_issue(5'd13, 4'd5);
                default: begin drive_reader(5'd13, 5'd0, 2'b01); flush = 1'b1; end
            endcase
            exp_q.push_back('{$sformatf("flush[%0d]", k), (k == 3) ? 7'b1_00_0000 : 7'b0_00_0000});
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, id_fwd, ex_fwd} !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, {stall, id_fwd, ex_fwd}, e.val);
            end
        end
    endtask

    // Three entries pending, reset asserted mid-cycle, then a fresh issue after release.
    task automatic test_reset_mid();
        exp_t e;
        for (int k = 0; k < 12; k++) begin
            logic exp_stall;
            exp_stall = 1'b0;
            if (k < 5 || k > 6) begin
                next_cycle();
            end
            case (k)
                0: drive_issue(5'd5, 4'd8);
                1: drive_issue(5'd6, 4'd8);
                2: drive_issue(5'd7, 4'd8);
                3: begin drive_reader(5'd5, 5'd0, 2'b01); exp_stall = 1'b1; end
                4: begin drive_reader(5'd5, 5'd0, 2'b01); #2 rst_n = 1'b0; end
                5: drive_reader(5'd6, 5'd0, 2'b01);
                6: drive_reader(5'd7, 5'd0, 2'b01);
                7: begin rst_n = 1'b1; drive_reader(5'd5, 5'd7, 2'b11); end
                8: drive_issue(5'd6, 4'd2);
                default: begin drive_reader(5'd6, 5'd0, 2'b01); exp_stall = (k < 11); end
            endcase
            exp_q.push_back('{$sformatf("reset_mid[%0d]", k), {exp_stall, 6'b00_0000}});
            if (k >= 4 && k <= 6) begin
                #1;
            end else begin
                @(negedge clk);
            end
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, id_fwd, ex_fwd} !== e.val) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, {stall, id_fwd, ex_fwd}, e.val);
            end
`ifdef FWD_STALL_CNT_EN
            if (k == 6) begin
                n_cmp++;
                if (stall_cnt !== 32'd0) begin
                    n_err++;
                    $display("FAIL stall_cnt_reset: got %0d expected 0", stall_cnt);
                end
            end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        test_reset();
        idle(2);
        test_load_use();
        idle(2);
        test_ex_fwd();
        idle(2);
        test_multicycle();
        idle(2);
        test_waw();
        idle(2);
        test_reissue();
        idle(2);
        test_branch();
        idle(2);
        test_flush();
        idle(16);
        test_reset_mid();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
